zigbee_cmd_parser: RTL and testbench
====================================

ZIGBEE_CMD_PARSER -- requirements
Module: zigbee_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: maximum clock cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter TIMEOUT_W, default 20: width of the inter-byte timeout counter.
REQ-004 SHALL have port clock, input, 1: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port rx_byte, input, 8: byte from the UART receiver; valid while received=1.
REQ-007 SHALL have port received, input, 1: byte strobe, synchronous to clock; each high cycle is one byte.
REQ-008 SHALL have port recv_error, input, 1: framing error flag for the byte strobed in the same cycle.
REQ-009 SHALL have port cmd_valid, output, 1: one-cycle pulse marking a new accepted command.
REQ-010 SHALL have ports cmd_op, cmd_arg0 and cmd_arg1, output, 8 each: fields of the last accepted frame.
REQ-011 SHALL have port frame_error, output, 1: one-cycle pulse when a frame is aborted.
REQ-012 SHALL have port error_count, output, 8: saturating count of aborted frames.
REQ-013 SHALL have port busy, output, 1: high when the state is not IDLE.

Function
REQ-014 SHALL implement a state machine with states IDLE, OP, ARG0, ARG1 and CHK; a byte is consumed only in a cycle where received=1.
REQ-015 SHALL, in IDLE, move to OP on a byte equal to SYNC_BYTE with recv_error=0, and ignore every other byte and any recv_error without reporting an error.
REQ-016 SHALL, in OP, ARG0 and ARG1, latch the byte into an internal shadow register and advance to the next state; a SYNC_BYTE value in these states is treated as data.
REQ-017 SHALL, in CHK, compare the byte with OP^ARG0^ARG1: on a match, update the cmd_* outputs from the shadow registers, pulse cmd_valid and return to IDLE; on a mismatch, pulse frame_error and return to IDLE.
REQ-018 SHALL assert cmd_valid and present the new cmd_* values in the cycle immediately after the cycle in which the final byte was strobed (one-cycle latency).
REQ-019 SHALL hold cmd_* outputs unchanged except on an accepted frame; aborted frames never modify them.
REQ-020 SHALL, in any non-IDLE state, treat received=1 with recv_error=1 as an abort: pulse frame_error and return to IDLE.
REQ-021 SHALL clear the timeout counter on every consumed byte and in IDLE, and increment it each cycle in non-IDLE states.
REQ-022 SHALL abort (pulse frame_error, return to IDLE) when the timeout counter reaches TIMEOUT_CYCLES-1 with no byte strobed in that cycle.
REQ-023 SHALL give a byte strobed in the same cycle as timeout expiry priority; the byte is consumed and no timeout occurs.
REQ-024 SHALL increment error_count by one on every frame_error pulse and saturate it at 255.
REQ-025 SHALL never assert cmd_valid and frame_error in the same cycle.

Reset
REQ-026 SHALL, with reset=1 at a clock edge, set the state to IDLE and clear the timeout counter, shadow registers, cmd_op, cmd_arg0, cmd_arg1, error_count, cmd_valid, frame_error and busy to 0.
REQ-027 SHALL, when reset is asserted mid-frame, discard the partial frame without pulsing frame_error and without incrementing error_count.

Configuration
REQ-028 SHALL use the macro ZIGBEE_CMD_PARSER_CHKSUM_EN: when defined, frames are 5 bytes (SYNC, OP, ARG0, ARG1, CHK) and the checksum is checked as specified above.
REQ-029 SHALL, when ZIGBEE_CMD_PARSER_CHKSUM_EN is undefined, omit the CHK state and checksum logic; frames are 4 bytes, and the ARG1 byte completes the frame with the same one-cycle latency.

Verification (CHKSUM_EN defined, TIMEOUT_CYCLES=16)
REQ-030 SHALL cover a good frame: bytes A5,01,80,40,C1 -> one cycle after the C1 strobe, cmd_valid=1 for one cycle, cmd_op=01, cmd_arg0=80, cmd_arg1=40, error_count=0.
REQ-031 SHALL cover a bad checksum: bytes A5,02,03,04,00 -> frame_error pulses once, error_count=1, cmd_* keep the previous values, cmd_valid stays 0.
REQ-032 SHALL cover leading junk: bytes 00,FF,A5,10,20,30,00 -> junk is ignored, frame accepted with cmd_op=10, cmd_arg0=20, cmd_arg1=30.
REQ-033 SHALL cover timeouts: A5,01 followed by 20 idle cycles -> frame_error on the 16th idle cycle, busy=0; a separate case strobing a byte exactly at cycle 15 -> no error.
REQ-034 SHALL cover recv_error mid-frame: recv_error=1 on the ARG0 byte -> frame_error pulses and state returns to IDLE.
REQ-035 SHALL cover saturation and reset: 260 bad frames -> error_count=255; then reset asserted mid-frame -> all outputs 0 and no frame_error pulse.

Source files
------------

// File: rtl/zigbee_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : zigbee_cmd_parser
// Description : Byte-stream command framer for a UART-fed Zigbee link.
//               Hunts for SYNC_BYTE, then collects OP, ARG0, ARG1 and
//               (optionally) an XOR checksum byte. A good frame updates the
//               cmd_* outputs and pulses cmd_valid one cycle after its last
//               byte. A framing error, a bad checksum or an inter-byte
//               timeout aborts the frame, pulses frame_error and bumps a
//               saturating error counter.
//
//               Optional feature macro: ZIGBEE_CMD_PARSER_CHKSUM_EN
//                 defined   -> 5-byte frames SYNC,OP,ARG0,ARG1,CHK where
//                              CHK must equal OP^ARG0^ARG1
//                 undefined -> 4-byte frames SYNC,OP,ARG0,ARG1
//
// Ports       : clock        - single rising-edge clock
//               reset        - synchronous, active-high reset
//               rx_byte      - received byte, valid while received=1
//               received     - one-cycle strobe per received byte
//               recv_error   - framing error for the strobed byte
//               cmd_valid    - one-cycle pulse on an accepted frame
//               cmd_op/arg0/arg1 - fields of the last accepted frame
//               frame_error  - one-cycle pulse on an aborted frame
//               error_count  - saturating count of aborted frames
//               busy         - parser is inside a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module zigbee_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         TIMEOUT_W      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       received,
    input  logic       recv_error,
    output logic       cmd_valid,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_arg0,
    output logic [7:0] cmd_arg1,
    output logic       frame_error,
    output logic [7:0] error_count,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_OP   = 3'd1;
    localparam logic [2:0] c_ST_ARG0 = 3'd2;
    localparam logic [2:0] c_ST_ARG1 = 3'd3;
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
    localparam logic [2:0] c_ST_CHK  = 3'd4;
    // State whose byte completes the frame
    localparam logic [2:0] c_ST_LAST = c_ST_CHK;
`else
    localparam logic [2:0] c_ST_LAST = c_ST_ARG1;
`endif

    localparam logic [TIMEOUT_W-1:0] c_TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           r_state;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [7:0]           r_op;
    logic [7:0]           r_arg0;
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
    logic [7:0]           r_arg1;
`endif

    logic       w_in_frame;
    logic       w_data_byte;
    logic       w_timeout;
    logic       w_final;
    logic       w_chk_ok;
    logic       w_accept;
    logic       w_abort;
    logic [7:0] w_new_arg1;

    always_comb begin
        w_in_frame  = (r_state != c_ST_IDLE);
        w_data_byte = w_in_frame && received && !recv_error;
        // A byte arriving in the expiry cycle wins over the timeout
        w_timeout   = w_in_frame && !received && (r_timer == c_TIMEOUT_LAST);
        w_final     = w_data_byte && (r_state == c_ST_LAST);
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
        w_chk_ok    = (rx_byte == (r_op ^ r_arg0 ^ r_arg1));
        w_new_arg1  = r_arg1;
`else
        // Without a checksum the ARG1 byte itself closes the frame
        w_chk_ok    = 1'b1;
        w_new_arg1  = rx_byte;
`endif
        w_accept    = w_final && w_chk_ok;
        w_abort     = (w_in_frame && received && recv_error) ||
                      w_timeout ||
                      (w_final && !w_chk_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_timer     <= '0;
            r_op        <= 8'h00;
            r_arg0      <= 8'h00;
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
            r_arg1      <= 8'h00;
`endif
            cmd_valid   <= 1'b0;
            cmd_op      <= 8'h00;
            cmd_arg0    <= 8'h00;
            cmd_arg1    <= 8'h00;
            frame_error <= 1'b0;
            error_count <= 8'h00;
            busy        <= 1'b0;
        end else begin
            cmd_valid   <= w_accept;
            frame_error <= w_abort;

            if (w_accept) begin
                cmd_op   <= r_op;
                cmd_arg0 <= r_arg0;
                cmd_arg1 <= w_new_arg1;
            end

            if (w_abort && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end

            // Idle gap counter: restarts on every byte and outside frames
            if (!w_in_frame || received) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_accept || w_abort) begin
                r_state <= c_ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (received && !recv_error && (rx_byte == SYNC_BYTE)) begin
                            r_state <= c_ST_OP;
                            busy    <= 1'b1;
                        end
                    end
                    c_ST_OP: begin
                        if (w_data_byte) begin
                            r_op    <= rx_byte;
                            r_state <= c_ST_ARG0;
                        end
                    end
                    c_ST_ARG0: begin
                        if (w_data_byte) begin
                            r_arg0  <= rx_byte;
                            r_state <= c_ST_ARG1;
                        end
                    end
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
                    c_ST_ARG1: begin
                        if (w_data_byte) begin
                            r_arg1  <= rx_byte;
                            r_state <= c_ST_CHK;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zigbee_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_zigbee_cmd_parser
// Description : Self-checking bench for zigbee_cmd_parser. A frame-level
//               reference model tracks the expected outputs every cycle;
//               directed frames pin the model with literal expectations,
//               then randomized traffic exercises junk, gaps, timeouts and
//               receive errors. Works with or without
//               ZIGBEE_CMD_PARSER_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zigbee_cmd_parser;

    localparam int         c_TO   = 16;
    localparam logic [7:0] c_SYNC = 8'hA5;
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
    localparam int         c_PAYLOAD = 4;
`else
    localparam int         c_PAYLOAD = 3;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       received = 1'b0;
    logic       recv_error = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_op;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic       frame_error;
    logic [7:0] error_count;
    logic       busy;

    zigbee_cmd_parser #(
        .SYNC_BYTE      (c_SYNC),
        .TIMEOUT_CYCLES (c_TO),
        .TIMEOUT_W      (5)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .rx_byte     (rx_byte),
        .received    (received),
        .recv_error  (recv_error),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_arg0    (cmd_arg0),
        .cmd_arg1    (cmd_arg1),
        .frame_error (frame_error),
        .error_count (error_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic       exp_valid, exp_ferr, exp_busy;
    logic [7:0] exp_op, exp_arg0, exp_arg1, exp_ecnt;
    logic [7:0] m_buf [4];
    int         m_n;
    int         m_idle;

    task automatic model_abort();
        exp_ferr = 1'b1;
        if (exp_ecnt != 8'd255) exp_ecnt = exp_ecnt + 8'd1;
        exp_busy = 1'b0;
    endtask

    always @(posedge clock) begin
        if (reset) begin
            exp_valid = 0; exp_ferr = 0; exp_busy = 0;
            exp_op = 0; exp_arg0 = 0; exp_arg1 = 0; exp_ecnt = 0;
            m_n = 0; m_idle = 0;
        end else begin
            exp_valid = 0;
            exp_ferr  = 0;
            if (!exp_busy) begin
                if (received && !recv_error && rx_byte == c_SYNC) begin
                    exp_busy = 1; m_n = 0; m_idle = 0;
                end
            end else if (received) begin
                m_idle = 0;
                if (recv_error) begin
                    model_abort();
                end else begin
                    m_buf[m_n] = rx_byte;
                    m_n++;
                    if (m_n == c_PAYLOAD) begin
                        if (c_PAYLOAD == 3 || m_buf[3] == (m_buf[0] ^ m_buf[1] ^ m_buf[2])) begin
                            exp_valid = 1;
                            exp_op = m_buf[0]; exp_arg0 = m_buf[1]; exp_arg1 = m_buf[2];
                            exp_busy = 0;
                        end else begin
                            model_abort();
                        end
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == c_TO) model_abort();
            end
        end
    end

    always @(negedge clock) begin
        if (run_cmp) begin
            chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, exp_valid});
            chk("frame_error", {31'd0, frame_error}, {31'd0, exp_ferr});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("cmd_fields", {8'd0, cmd_op, cmd_arg0, cmd_arg1}, {8'd0, exp_op, exp_arg0, exp_arg1});
            chk("error_count", {24'd0, error_count}, {24'd0, exp_ecnt});
            chk("valid_ferr_excl", {31'd0, cmd_valid & frame_error}, 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            received = 1'b0; recv_error = 1'b0;
        end
    endtask

    task automatic put(input logic [7:0] b, input logic e);
        @(posedge clock); #1;
        received = 1'b1; rx_byte = b; recv_error = e;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a0,
                              input logic [7:0] a1, input logic [7:0] ck);
        put(c_SYNC, 1'b0); put(op, 1'b0); put(a0, 1'b0); put(a1, 1'b0);
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
        put(ck, 1'b0);
`else
        if (ck == 8'hFF) rx_byte = rx_byte; // checksum byte is not sent in 4-byte mode
`endif
    endtask

    int         lit_errs;
    int         kind;
    logic [7:0] f [4];

    initial begin
        lit_errs = 0;
        idle(3);
        run_cmp = 1'b1;
        @(negedge clock);
        chk("reset_outputs", {busy, cmd_valid, frame_error, cmd_op, cmd_arg0, cmd_arg1, error_count}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // Good frame
        send_frame(8'h01, 8'h80, 8'h40, 8'hC1);
        idle(1);
        @(negedge clock);
        chk("good_valid", {31'd0, cmd_valid}, 32'd1);
        chk("good_fields", {8'd0, cmd_op, cmd_arg0, cmd_arg1}, 32'h00018040);
        chk("good_ecnt", {24'd0, error_count}, 32'd0);

`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
        // Bad checksum
        send_frame(8'h02, 8'h03, 8'h04, 8'h00);
        idle(1);
        lit_errs++;
        @(negedge clock);
        chk("badck_ferr", {31'd0, frame_error}, 32'd1);
        chk("badck_valid", {31'd0, cmd_valid}, 32'd0);
        chk("badck_ecnt", {24'd0, error_count}, lit_errs);
        chk("badck_fields_kept", {8'd0, cmd_op, cmd_arg0, cmd_arg1}, 32'h00018040);
`endif

        // Leading junk
        put(8'h00, 1'b0); put(8'hFF, 1'b0);
        send_frame(8'h10, 8'h20, 8'h30, 8'h00);
        idle(1);
        @(negedge clock);
        chk("junk_valid", {31'd0, cmd_valid}, 32'd1);
        chk("junk_fields", {8'd0, cmd_op, cmd_arg0, cmd_arg1}, 32'h00102030);

        // Timeout: abort lands on the 16th idle cycle
        put(c_SYNC, 1'b0); put(8'h01, 1'b0);
        idle(16);
        @(negedge clock);
        chk("to_pre_ferr", {31'd0, frame_error}, 32'd0);
        chk("to_pre_busy", {31'd0, busy}, 32'd1);
        idle(1);
        lit_errs++;
        @(negedge clock);
        chk("to_ferr", {31'd0, frame_error}, 32'd1);
        chk("to_busy", {31'd0, busy}, 32'd0);
        chk("to_ecnt", {24'd0, error_count}, lit_errs);
        idle(4);

        // Byte strobed exactly in the expiry cycle wins
        put(c_SYNC, 1'b0); put(8'h01, 1'b0);
        idle(15);
        put(8'h80, 1'b0); put(8'h40, 1'b0);
`ifdef ZIGBEE_CMD_PARSER_CHKSUM_EN
        put(8'hC1, 1'b0);
`endif
        idle(1);
        @(negedge clock);
        chk("edge_valid", {31'd0, cmd_valid}, 32'd1);
        chk("edge_ecnt", {24'd0, error_count}, lit_errs);

        // recv_error on the ARG0 byte
        put(c_SYNC, 1'b0); put(8'h11, 1'b0); put(8'h22, 1'b1);
        idle(1);
        lit_errs++;
        @(negedge clock);
        chk("rxerr_ferr", {31'd0, frame_error}, 32'd1);
        chk("rxerr_busy", {31'd0, busy}, 32'd0);
        chk("rxerr_ecnt", {24'd0, error_count}, lit_errs);
        chk("rxerr_fields_kept", {8'd0, cmd_op, cmd_arg0, cmd_arg1}, 32'h00018040);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                f[0] = 8'($urandom); f[1] = 8'($urandom); f[2] = 8'($urandom);
                f[3] = f[0] ^ f[1] ^ f[2] ^
                       (($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
                put(c_SYNC, 1'b0);
                for (int k = 0; k < c_PAYLOAD; k++) begin
                    if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 18));
                    put(f[k], ($urandom_range(0, 29) == 0));
                end
            end else if (kind < 8) begin
                put(8'($urandom), ($urandom_range(0, 3) == 0));
            end else begin
                idle($urandom_range(1, 5));
            end
        end
        idle(20);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            put(c_SYNC, 1'b0); put(8'h00, 1'b1);
        end
        idle(2);
        @(negedge clock);
        chk("sat_ecnt", {24'd0, error_count}, 32'd255);

        // Reset in the middle of a frame
        put(c_SYNC, 1'b0); put(8'h01, 1'b0);
        idle(1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_outputs", {busy, cmd_valid, frame_error, cmd_op, cmd_arg0, cmd_arg1, error_count}, 32'd0);
        idle(20);
        @(negedge clock);
        chk("midrst_no_err", {24'd0, error_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
